// File: rtl/fabric_tag_merge.sv
// Round-robin merge of NUM_INPUTS untagged streams into a single tagged stream.
// Output word is {tag, value}, with the tag being the index of the winning input.
module fabric_tag_merge #(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_INPUTS-1:0]                in_valid,
  output logic [NUM_INPUTS-1:0]                in_ready,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0]     in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DATA_WIDTH+TAG_WIDTH-1:0]      out_data
);

  localparam int PTR_W  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int SLOT_W = DATA_WIDTH + TAG_WIDTH;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_INPUTS - 1);

  if (NUM_INPUTS < 2) begin : g_chk_num_inputs
    $fatal(1, "CPL_TAG_MERGE_NUM_INPUTS: NUM_INPUTS must be >= 2");
  end
  if (DATA_WIDTH < 1) begin : g_chk_data_width
    $fatal(1, "CPL_TAG_MERGE_DATA_WIDTH: DATA_WIDTH must be >= 1");
  end
  if ((TAG_WIDTH < 1) ||
      ((TAG_WIDTH < 31) && ((32'd1 << TAG_WIDTH) < NUM_INPUTS))) begin : g_chk_tag_width
    $fatal(1, "CPL_TAG_MERGE_TAG_WIDTH: TAG_WIDTH too small for NUM_INPUTS");
  end

  logic                   full_q;
  logic                   full_d;
  logic [SLOT_W-1:0]      slot_q;
  logic [SLOT_W-1:0]      slot_d;
  logic [PTR_W-1:0]       rr_ptr_q;
  logic [PTR_W-1:0]       rr_ptr_d;

  logic                   can_accept_s;
  logic                   win_found_s;
  logic [PTR_W-1:0]       win_idx_s;
  logic [DATA_WIDTH-1:0]  win_data_s;
  logic                   transfer_s;

  assign can_accept_s = !full_q || out_ready;
  assign transfer_s   = win_found_s && can_accept_s && !rst;

  // Cyclic priority search starting at rr_ptr_q; the first valid input wins.
  always_comb begin : p_grant
    int cand;
    cand        = 0;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    win_data_s  = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_INPUTS) begin
        cand = cand - NUM_INPUTS;
      end else begin
        cand = cand;
      end
      if (!win_found_s && in_valid[cand]) begin
        win_found_s = 1'b1;
        win_idx_s   = PTR_W'(cand);
        win_data_s  = in_data[cand*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // One-hot ready toward the winner only; never a function of in_data.
  always_comb begin
    in_ready = '0;
    if (transfer_s) begin
      in_ready[win_idx_s] = 1'b1;
    end else begin
      in_ready = '0;
    end
  end

  // Slot and pointer next state: a transfer refills (possibly while draining).
  always_comb begin
    full_d   = full_q;
    slot_d   = slot_q;
    rr_ptr_d = rr_ptr_q;
    if (transfer_s) begin
      full_d   = 1'b1;
      slot_d   = {TAG_WIDTH'(win_idx_s), win_data_s};
      rr_ptr_d = (win_idx_s == LAST_IDX) ? '0 : (win_idx_s + PTR_W'(1));
    end else if (full_q && out_ready) begin
      full_d   = 1'b0;
    end else begin
      full_d   = full_q;
    end
  end

  // State registers with synchronous reset; a word in the slot is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q   <= 1'b0;
      slot_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      full_q   <= full_d;
      slot_q   <= slot_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign out_valid = full_q;
  assign out_data  = slot_q;

endmodule
